multdiv_scheduler: RTL and testbench

MULTDIV_SCHEDULER -- requirements
Module: multdiv_scheduler

---
 rtl/multdiv_scheduler_if.sv | 35 +++
 rtl/multdiv_scheduler.sv | 112 +++++++++++
 tb/tb_multdiv_scheduler.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_scheduler_if.sv
// Decode/writeback and multdiv-unit signals of the multdiv scheduler.
// master = scheduler side, slave = pipeline/unit side.
interface multdiv_scheduler_if;
    logic        start_mult;
    logic        start_div;
    logic [31:0] DX_A;
    logic [31:0] DX_B;
    logic [4:0]  DX_rd;
    logic [31:0] md_result;
    logic        md_resultRDY;
    logic        md_exception;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] op_A;
    logic [31:0] op_B;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        busy;

    modport master (
        input  start_mult, start_div, DX_A, DX_B, DX_rd,
        input  md_result, md_resultRDY, md_exception,
        output ctrl_MULT, ctrl_DIV, op_A, op_B, stall,
        output wb_valid, wb_data, wb_rd, busy
    );

    modport slave (
        output start_mult, start_div, DX_A, DX_B, DX_rd,
        output md_result, md_resultRDY, md_exception,
        input  ctrl_MULT, ctrl_DIV, op_A, op_B, stall,
        input  wb_valid, wb_data, wb_rd, busy
    );
endinterface

// File: rtl/multdiv_scheduler.sv
// Sequences one mul/div at a time through the multdiv unit, stalling
// the front end and injecting the result (or status) into writeback.
module multdiv_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter int unsigned MULT_STATUS    = 4,
    parameter int unsigned DIV_STATUS     = 5
) (
    input  logic                clock,
    input  logic                reset_n,
    multdiv_scheduler_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE, S_ISSUE, S_BUSY, S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_is_mult;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [4:0]  r_rd;
    logic [5:0]  r_cnt;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_rd;
    logic        w_start;
    logic [5:0]  w_cnt_inc;
    logic        w_timeout;
    logic [31:0] w_status;

    assign w_start   = bus.start_mult | bus.start_div;
    assign w_cnt_inc = (r_cnt == 6'h3f) ? r_cnt : r_cnt + 6'd1;
    // Counter holds completed BUSY cycles, so this fires on the last allowed one.
    assign w_timeout = (w_cnt_inc == 6'(TIMEOUT_CYCLES));
    assign w_status  = r_is_mult ? 32'(MULT_STATUS) : 32'(DIV_STATUS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        bus.stall     = 1'b0;
        bus.busy      = 1'b0;
        bus.wb_valid  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                bus.stall = w_start;
                if (w_start) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                bus.ctrl_MULT = r_is_mult;
                bus.ctrl_DIV  = ~r_is_mult;
                bus.stall     = 1'b1;
                bus.busy      = 1'b1;
                w_next        = S_BUSY;
            end
            S_BUSY: begin
                bus.stall = 1'b1;
                bus.busy  = 1'b1;
                if (bus.md_resultRDY || w_timeout) w_next = S_DONE;
            end
            S_DONE: begin
                bus.wb_valid = 1'b1;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_is_mult <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_wb_data <= '0;
            r_wb_rd   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_is_mult <= bus.start_mult;
                        r_op_a    <= bus.DX_A;
                        r_op_b    <= bus.DX_B;
                        r_rd      <= bus.DX_rd;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_BUSY: begin
                    r_cnt <= w_cnt_inc;
                    if (bus.md_resultRDY) begin
                        r_wb_data <= bus.md_exception ? w_status : bus.md_result;
                        r_wb_rd   <= bus.md_exception ? 5'd30 : r_rd;
                    end else if (w_timeout) begin
                        r_wb_data <= w_status;
                        r_wb_rd   <= 5'd30;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.op_A    = r_op_a;
    assign bus.op_B    = r_op_b;
    assign bus.wb_data = r_wb_data;
    assign bus.wb_rd   = r_wb_rd;
endmodule

// File: tb/tb_multdiv_scheduler.sv
// Randomized and directed bench for multdiv_scheduler against a
// per-operation outcome model (latency, counts, writeback values).
module tb_multdiv_scheduler;
    localparam int TO = 40;

    logic clock = 1'b0;
    logic reset_n;
    int   n_chk = 0;
    int   n_err = 0;
    int   gcyc = 0;
    int   last_issue = -1;

    multdiv_scheduler_if bus ();

    multdiv_scheduler #(
        .TIMEOUT_CYCLES(TO),
        .MULT_STATUS(4),
        .DIV_STATUS(5)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus.master)
    );

    always #5 clock = ~clock;
    always @(posedge clock) gcyc <= gcyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.start_mult   = 1'b0;
        bus.start_div    = 1'b0;
        bus.DX_A         = '0;
        bus.DX_B         = '0;
        bus.DX_rd        = '0;
        bus.md_result    = '0;
        bus.md_resultRDY = 1'b0;
        bus.md_exception = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrlM"}, 32'(bus.ctrl_MULT), 0);
        chk({tag, "_ctrlD"}, 32'(bus.ctrl_DIV), 0);
        chk({tag, "_opA"}, bus.op_A, 0);
        chk({tag, "_opB"}, bus.op_B, 0);
        chk({tag, "_wbv"}, 32'(bus.wb_valid), 0);
        chk({tag, "_wbd"}, bus.wb_data, 0);
        chk({tag, "_wbrd"}, 32'(bus.wb_rd), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    // lat: BUSY cycle in which the unit answers (0 = never).
    task automatic run_op(input bit m, input bit d, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input int lat, input logic [31:0] res,
                          input bit exc, input bit spur, input bit keep,
                          input bit now);
        bit          is_mult = m;
        bit          to = (lat == 0) || (lat > TO);
        int          elat = to ? TO : lat;
        logic [31:0] edata;
        logic [4:0]  erd;
        int nm = 0, nd = 0, nst = 0, nbz = 0, nwb = 0, done_c = -1;
        if (to || exc) begin
            erd   = 5'd30;
            edata = is_mult ? 32'd4 : 32'd5;
        end else begin
            erd   = rd;
            edata = res;
        end
        for (int c = 0; c < 80 && done_c < 0; c++) begin
            if (!(now && c == 0)) @(negedge clock);
            if (c == 0) begin
                bus.start_mult = m;
                bus.start_div  = d;
                bus.DX_A       = a;
                bus.DX_B       = b;
                bus.DX_rd      = rd;
            end
            bus.md_resultRDY = (lat != 0) && (c == 1 + lat);
            bus.md_result    = bus.md_resultRDY ? res : $urandom;
            bus.md_exception = bus.md_resultRDY ? exc : 1'($urandom);
            #1;
            if (bus.ctrl_MULT) nm++;
            if (bus.ctrl_DIV) nd++;
            if (bus.ctrl_MULT || bus.ctrl_DIV) begin
                if (last_issue >= 0)
                    chk("issue_gap_ge4", 32'((gcyc - last_issue) >= 4), 1);
                last_issue = gcyc;
            end
            if (bus.stall) nst++;
            if (bus.busy) nbz++;
            if (c == 1) begin
                chk("opA_latched", bus.op_A, a);
                chk("opB_latched", bus.op_B, b);
                if (spur) bus.md_resultRDY = 1'b1;
            end
            if (bus.wb_valid) begin
                nwb++;
                done_c = c;
                chk("wb_data", bus.wb_data, edata);
                chk("wb_rd", 32'(bus.wb_rd), 32'(erd));
                chk("opA_hold", bus.op_A, a);
                if (!keep) begin
                    bus.start_mult = 1'b0;
                    bus.start_div  = 1'b0;
                end
            end
        end
        chk("done_cycle", done_c, elat + 2);
        chk("ctrl_MULT_cnt", nm, is_mult ? 1 : 0);
        chk("ctrl_DIV_cnt", nd, is_mult ? 0 : 1);
        chk("stall_cycles", nst, elat + 2);
        chk("busy_cycles", nbz, elat + 1);
        chk("wb_valid_cnt", nwb, 1);
        if (!keep) begin
            @(negedge clock);
            bus.md_resultRDY = to;
            bus.md_result    = 32'hdead_beef;
            bus.md_exception = 1'b0;
            #1;
            chk("post_wbv", 32'(bus.wb_valid), 0);
            chk("post_busy", 32'(bus.busy), 0);
            @(negedge clock);
            bus.md_resultRDY = 1'b0;
            #1;
            chk("late_busy", 32'(bus.busy), 0);
            chk("late_wbv", 32'(bus.wb_valid), 0);
            chk("hold_wbd", bus.wb_data, edata);
            chk("hold_wbrd", 32'(bus.wb_rd), 32'(erd));
        end
    endtask

    task automatic reset_mid_busy();
        @(negedge clock);
        bus.start_mult = 1'b1;
        bus.DX_A       = 32'h1234;
        bus.DX_B       = 32'h5678;
        bus.DX_rd      = 5'd9;
        for (int i = 0; i < 12; i++) @(negedge clock);
        #1;
        chk("pre_rst_busy", 32'(bus.busy), 1);
        bus.start_mult = 1'b0;
        reset_n        = 1'b0;
        #1;
        chk_zero("rst_mid");
        chk("rst_mid_stall", 32'(bus.stall), 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.md_resultRDY = (i == 0);
            bus.md_result    = 32'h77;
            #1;
            chk("rst_after_wbv", 32'(bus.wb_valid), 0);
            chk("rst_after_busy", 32'(bus.busy), 0);
        end
        bus.md_resultRDY = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk_zero("reset");
        chk("reset_stall", 32'(bus.stall), 0);
        @(negedge clock);
        reset_n = 1'b1;
        run_op(1, 0, 7, 6, 5, 17, 42, 0, 0, 0, 1);
        run_op(0, 1, 9, 0, 3, 5, 32'h1111, 1, 0, 0, 0);
        run_op(1, 0, 3, 4, 7, 0, 0, 0, 0, 0, 0);
        run_op(1, 1, 2, 2, 8, 3, 32'h99, 1, 0, 0, 0);
        run_op(0, 1, 50, 5, 0, 2, 10, 0, 0, 0, 0);
        run_op(1, 0, 11, 12, 13, 40, 32'habcd, 0, 0, 0, 0);
        run_op(0, 1, 11, 12, 14, 41, 32'habcd, 0, 0, 0, 0);
        run_op(1, 0, 1, 1, 15, 1, 32'h5a5a, 0, 1, 0, 0);
        run_op(1, 0, 21, 22, 23, 1, 32'h100, 0, 0, 1, 0);
        run_op(1, 0, 21, 22, 23, 2, 32'h200, 0, 0, 0, 0);
        run_op(0, 1, 8, 2, 6, 6, 4, 0, 1, 0, 0);
        reset_mid_busy();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        run_op(0, 1, 100, 7, 17, 4, 14, 0, 0, 0, 1);
        for (int i = 0; i < 30; i++) begin
            int  sel = int'($urandom_range(0, 2));
            int  lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 45));
            bit  exc = ($urandom_range(0, 3) == 0);
            run_op(sel != 1, sel != 0, $urandom, $urandom, 5'($urandom),
                   lat, $urandom, exc, 1'($urandom), 0, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
